// File: rtl/hiscore_save.sv
// hiscore_save: verifies the configured hiscore regions in game RAM, copies
// them into a local save buffer and serves that buffer to the HPS over the
// ioctl upload path. Config records are the same 8-byte records used by the
// restore path.
module hiscore_save #(
    parameter int ENTRIES_W = 4,
    parameter int BUF_AW    = 6,
    parameter int RAM_AW    = 10,
    parameter int CFG_INDEX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_upload,
    output logic [7:0]        ioctl_din,
    input  logic              save_req,
    output logic [RAM_AW-1:0] ram_address,
    output logic              ram_read,
    input  logic [7:0]        ram_data_in,
    output logic              busy,
    output logic              ready,
    output logic              overflow,
    output logic [BUF_AW:0]   total_bytes
);

    localparam int ENTRIES = 1 << ENTRIES_W;
    localparam int BUF_SZ  = 1 << BUF_AW;

    localparam logic [ENTRIES_W:0] ENT_ZERO = (ENTRIES_W+1)'(0);
    localparam logic [ENTRIES_W:0] ENT_ONE  = (ENTRIES_W+1)'(1);
    localparam logic [BUF_AW:0]    BUF_ZERO = (BUF_AW+1)'(0);
    localparam logic [BUF_AW:0]    BUF_ONE  = (BUF_AW+1)'(1);
    localparam logic [BUF_AW:0]    BUF_FULL = (BUF_AW+1)'(BUF_SZ);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHK_S     = 3'd1,
        S_CHK_E     = 3'd2,
        S_COPY_INIT = 3'd3,
        S_COPY      = 3'd4,
        S_DRAIN     = 3'd5,
        S_DONE      = 3'd6,
        S_FAIL      = 3'd7
    } state_t;

    // Replace the address bits carried by one big-endian byte (offset 1 = bits
    // 23:16, 2 = 15:8, 3 = 7:0); bits beyond RAM_AW are simply dropped.
    function automatic logic [RAM_AW-1:0] merge_addr(input logic [RAM_AW-1:0] cur,
                                                     input logic [2:0]        off,
                                                     input logic [7:0]        d);
        logic [RAM_AW-1:0] r;
        r = cur;
        for (int i = 0; i < RAM_AW; i++) begin
            if (int'(off) == 3 - (i / 8)) begin
                r[i] = d[i % 8];
            end else begin
                r[i] = cur[i];
            end
        end
        return r;
    endfunction

    // Config table (intentionally not cleared by reset)
    logic [RAM_AW-1:0] cfg_addr_q [ENTRIES];
    logic [7:0]        cfg_len_q  [ENTRIES];
    logic [7:0]        cfg_sv_q   [ENTRIES];
    logic [7:0]        cfg_ev_q   [ENTRIES];

    logic [7:0]        save_buf_q [BUF_SZ];

    state_t            state_q;
    logic              busy_q, ready_q, overflow_q;
    logic              ram_read_q;
    logic [RAM_AW-1:0] ram_address_q;
    logic [BUF_AW:0]   total_bytes_q;
    logic [7:0]        ioctl_din_q;
    logic [ENTRIES_W:0] entry_cnt_q, entry_q;
    logic [7:0]        k_q;
    logic [BUF_AW:0]   wptr_q, iss_q;
    // check-read pipeline: p1 = address on the bus, p2 = data on ram_data_in
    logic              p1_q, p2_q;
    logic [7:0]        p1_exp_q, p2_exp_q;
    // copy-read pipeline, same staging
    logic              c1_q, c2_q;

    logic                 cfg_wr_s;
    logic [ENTRIES_W-1:0] cfg_rec_s;
    logic [2:0]           cfg_off_s;
    logic [ENTRIES_W:0]   cnt_next_s;
    logic [RAM_AW-1:0]    cfg_addr_d;
    logic [ENTRIES_W-1:0] cur_idx_s;
    logic [RAM_AW-1:0]    cur_addr_s, cur_end_s, cur_copy_s;
    logic [7:0]           cur_len_s;
    logic                 last_entry_s, mism_s, buf_we_s;

    // Decode config writes and the fields of the entry currently being processed
    always_comb begin
        cfg_wr_s     = ioctl_download & ioctl_wr & (ioctl_index == 8'(CFG_INDEX));
        cfg_rec_s    = ioctl_addr[ENTRIES_W+2:3];
        cfg_off_s    = ioctl_addr[2:0];
        cnt_next_s   = {1'b0, cfg_rec_s} + ENT_ONE;
        cfg_addr_d   = merge_addr(cfg_addr_q[cfg_rec_s], cfg_off_s, ioctl_dout);
        cur_idx_s    = entry_q[ENTRIES_W-1:0];
        cur_addr_s   = cfg_addr_q[cur_idx_s];
        cur_len_s    = cfg_len_q[cur_idx_s];
        cur_end_s    = cur_addr_s + RAM_AW'(cur_len_s) - RAM_AW'(1);
        cur_copy_s   = cur_addr_s + RAM_AW'(k_q);
        last_entry_s = ((entry_q + ENT_ONE) == entry_cnt_q);
        mism_s       = p2_q & (ram_data_in != p2_exp_q);
        buf_we_s     = c2_q & ((state_q == S_COPY) | (state_q == S_DRAIN)) & ~reset;
    end

    // Config table capture from the HPS download stream
    always_ff @(posedge clk) begin
        if (cfg_wr_s) begin
            case (cfg_off_s)
                3'd1, 3'd2, 3'd3: cfg_addr_q[cfg_rec_s] <= cfg_addr_d;
                3'd4:             cfg_len_q[cfg_rec_s]  <= ioctl_dout;
                3'd5:             cfg_sv_q[cfg_rec_s]   <= ioctl_dout;
                3'd6:             cfg_ev_q[cfg_rec_s]   <= ioctl_dout;
                default:          ;
            endcase
        end
    end

    // Save buffer write port, fed by returning copy reads
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            save_buf_q[wptr_q[BUF_AW-1:0]] <= ram_data_in;
        end
    end

    // Upload port: one-cycle registered buffer read, zero outside the valid capture
    always_ff @(posedge clk) begin
        if (reset) begin
            ioctl_din_q <= 8'h00;
        end else if (ioctl_upload) begin
            if (ready_q && (ioctl_addr < 25'(total_bytes_q))) begin
                ioctl_din_q <= save_buf_q[ioctl_addr[BUF_AW-1:0]];
            end else begin
                ioctl_din_q <= 8'h00;
            end
        end else begin
            ioctl_din_q <= ioctl_din_q;
        end
    end

    // Capture state machine: verify start/end markers, then copy into the buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            ready_q       <= 1'b0;
            overflow_q    <= 1'b0;
            ram_read_q    <= 1'b0;
            ram_address_q <= {RAM_AW{1'b0}};
            total_bytes_q <= BUF_ZERO;
            entry_cnt_q   <= ENT_ZERO;
            entry_q       <= ENT_ZERO;
            k_q           <= 8'h00;
            wptr_q        <= BUF_ZERO;
            iss_q         <= BUF_ZERO;
            p1_q          <= 1'b0;
            p2_q          <= 1'b0;
            p1_exp_q      <= 8'h00;
            p2_exp_q      <= 8'h00;
            c1_q          <= 1'b0;
            c2_q          <= 1'b0;
        end else begin
            if (cfg_wr_s && (cnt_next_s > entry_cnt_q)) begin
                entry_cnt_q <= cnt_next_s;
            end
            if (ioctl_download) begin
                ready_q <= 1'b0;
            end
            // a read is only presented on cycles where a state below issues one
            ram_read_q <= 1'b0;
            p1_q       <= 1'b0;
            p2_q       <= p1_q;
            p2_exp_q   <= p1_exp_q;
            c1_q       <= 1'b0;
            c2_q       <= c1_q;
            if (c2_q && ((state_q == S_COPY) || (state_q == S_DRAIN))) begin
                wptr_q <= wptr_q + BUF_ONE;
            end

            if (cfg_wr_s && (state_q != S_IDLE)) begin
                // config changing under us: drop the capture entirely
                state_q    <= S_IDLE;
                busy_q     <= 1'b0;
                ready_q    <= 1'b0;
                overflow_q <= 1'b0;
                p2_q       <= 1'b0;
                c2_q       <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (save_req && (entry_cnt_q != ENT_ZERO) && !ioctl_upload && !cfg_wr_s) begin
                            state_q    <= S_CHK_S;
                            busy_q     <= 1'b1;
                            entry_q    <= ENT_ZERO;
                            ready_q    <= 1'b0;
                            overflow_q <= 1'b0;
                        end
                    end
                    S_CHK_S: begin
                        if (mism_s) begin
                            state_q <= S_FAIL;
                        end else if (cur_len_s == 8'h00) begin
                            entry_q <= entry_q + ENT_ONE;
                            state_q <= last_entry_s ? S_COPY_INIT : S_CHK_S;
                        end else begin
                            ram_address_q <= cur_addr_s;
                            ram_read_q    <= 1'b1;
                            p1_q          <= 1'b1;
                            p1_exp_q      <= cfg_sv_q[cur_idx_s];
                            state_q       <= S_CHK_E;
                        end
                    end
                    S_CHK_E: begin
                        if (mism_s) begin
                            state_q <= S_FAIL;
                        end else begin
                            ram_address_q <= cur_end_s;
                            ram_read_q    <= 1'b1;
                            p1_q          <= 1'b1;
                            p1_exp_q      <= cfg_ev_q[cur_idx_s];
                            entry_q       <= entry_q + ENT_ONE;
                            state_q       <= last_entry_s ? S_COPY_INIT : S_CHK_S;
                        end
                    end
                    S_COPY_INIT: begin
                        // wait until the last marker compare is in flight on this edge
                        if (mism_s) begin
                            state_q <= S_FAIL;
                        end else if (!p1_q) begin
                            entry_q <= ENT_ZERO;
                            k_q     <= 8'h00;
                            wptr_q  <= BUF_ZERO;
                            iss_q   <= BUF_ZERO;
                            state_q <= S_COPY;
                        end
                    end
                    S_COPY: begin
                        if (entry_q == entry_cnt_q) begin
                            state_q <= S_DRAIN;
                        end else if (cur_len_s == 8'h00) begin
                            entry_q <= entry_q + ENT_ONE;
                        end else if (iss_q == BUF_FULL) begin
                            overflow_q <= 1'b1;
                            state_q    <= S_DRAIN;
                        end else begin
                            ram_address_q <= cur_copy_s;
                            ram_read_q    <= 1'b1;
                            c1_q          <= 1'b1;
                            iss_q         <= iss_q + BUF_ONE;
                            if (k_q == (cur_len_s - 8'd1)) begin
                                k_q     <= 8'h00;
                                entry_q <= entry_q + ENT_ONE;
                                state_q <= last_entry_s ? S_DRAIN : S_COPY;
                            end else begin
                                k_q <= k_q + 8'd1;
                            end
                        end
                    end
                    S_DRAIN: begin
                        // last returning byte (if any) is written on this edge
                        if (!c1_q) begin
                            state_q <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        total_bytes_q <= wptr_q;
                        ready_q       <= ~ioctl_download;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                    S_FAIL: begin
                        ready_q       <= 1'b0;
                        total_bytes_q <= BUF_ZERO;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ioctl_din   = ioctl_din_q;
    assign ram_address = ram_address_q;
    assign ram_read    = ram_read_q;
    assign busy        = busy_q;
    assign ready       = ready_q;
    assign overflow    = overflow_q;
    assign total_bytes = total_bytes_q;

endmodule
